// File: rtl/ex_mem_pkg.sv
// Shared types and defaults for the EX/MEM pipeline register and its memory-access FSM.
package ex_mem_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_ERR  = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
        logic link;
        logic halt;
        logic create_dump;
    } ctrl_t;

    // A squashed instruction keeps its data but loses every side effect.
    function automatic ctrl_t squash_ctrl(input ctrl_t c);
        ctrl_t r;
        r             = c;
        r.reg_write   = 1'b0;
        r.mem_write   = 1'b0;
        r.mem_read    = 1'b0;
        r.halt        = 1'b0;
        r.create_dump = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake FSM: request strobes, pipeline stall and sticky error state.
module mem_access_fsm
    import ex_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic mem_done_i,
    input  logic mem_err_i,
    input  logic misalign_i,
    output logic mem_rd_o,
    output logic mem_wr_o,
    output logic stall_o,
    output logic err_o
);

    mem_state_e state_q, state_d;
    logic       access;

    assign access = rd_req_i | wr_req_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // IDLE and BUSY drive identical strobes; BUSY only records that the access spans edges.
    always_comb begin
        state_d  = state_q;
        mem_rd_o = 1'b0;
        mem_wr_o = 1'b0;
        stall_o  = 1'b0;
        err_o    = 1'b0;
        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (access && !misalign_i) begin
                    mem_wr_o = wr_req_i;
                    mem_rd_o = rd_req_i & ~wr_req_i;
                    stall_o  = ~mem_done_i;
                end
                if (mem_err_i || (access && misalign_i)) state_d = ST_ERR;
                else if (access && !mem_done_i)          state_d = ST_BUSY;
                else                                     state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_o = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register driving the data-memory port; stalls upstream during multi-cycle accesses.
// Define EX_MEM_ALIGN_CHECK_EN to trap odd-address accesses into the error state.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     read2Data_in,
    input  logic [DATA_W-1:0]     PC_plus_two_in,
    input  logic [REG_ADDR_W-1:0] Write_register_in,
    input  logic                  RegWrite_in,
    input  logic                  MemWrite_in,
    input  logic                  MemRead_in,
    input  logic                  MemtoReg_in,
    input  logic                  link_in,
    input  logic                  halt_in,
    input  logic                  createdump_in,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     mem_DataOut,
    input  logic                  mem_Done,
    input  logic                  mem_err,
    output logic [DATA_W-1:0]     mem_Addr,
    output logic [DATA_W-1:0]     mem_DataIn,
    output logic                  mem_Rd,
    output logic                  mem_Wr,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [DATA_W-1:0]     PC_plus_two_out,
    output logic [REG_ADDR_W-1:0] Write_register_out,
    output logic                  RegWrite_out,
    output logic                  MemtoReg_out,
    output logic                  link_out,
    output logic                  halt_out,
    output logic                  createdump_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic                  stall_out,
    output logic                  err_out
);

    logic [DATA_W-1:0]     alu_q, r2_q, pc2_q;
    logic [REG_ADDR_W-1:0] wreg_q;
    ctrl_t                 ctrl_in, ctrl_d, ctrl_q;
    logic                  misalign;

    assign ctrl_in = '{reg_write:   RegWrite_in,
                       mem_write:   MemWrite_in,
                       mem_read:    MemRead_in,
                       mem_to_reg:  MemtoReg_in,
                       link:        link_in,
                       halt:        halt_in,
                       create_dump: createdump_in};
    assign ctrl_d  = flush ? squash_ctrl(ctrl_in) : ctrl_in;

    // Bundle register; a stall freezes it, which also drops any flush aimed at the held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q  <= '0;
            r2_q   <= '0;
            pc2_q  <= '0;
            wreg_q <= '0;
            ctrl_q <= '0;
        end else if (!stall_out) begin
            alu_q  <= ALU_result_in;
            r2_q   <= read2Data_in;
            pc2_q  <= PC_plus_two_in;
            wreg_q <= Write_register_in;
            ctrl_q <= ctrl_d;
        end
    end

`ifdef EX_MEM_ALIGN_CHECK_EN
    assign misalign = alu_q[0];
`else
    assign misalign = 1'b0;
`endif

    mem_access_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .rd_req_i   (ctrl_q.mem_read  & ~ctrl_q.halt),
        .wr_req_i   (ctrl_q.mem_write & ~ctrl_q.halt),
        .mem_done_i (mem_Done),
        .mem_err_i  (mem_err),
        .misalign_i (misalign),
        .mem_rd_o   (mem_Rd),
        .mem_wr_o   (mem_Wr),
        .stall_o    (stall_out),
        .err_o      (err_out)
    );

    assign mem_Addr           = alu_q;
    assign mem_DataIn         = r2_q;
    assign ALU_result_out     = alu_q;
    assign PC_plus_two_out    = pc2_q;
    assign Write_register_out = wreg_q;
    assign RegWrite_out       = ctrl_q.reg_write & ~err_out;
    assign MemtoReg_out       = ctrl_q.mem_to_reg;
    assign link_out           = ctrl_q.link;
    assign halt_out           = ctrl_q.halt;
    assign createdump_out     = ctrl_q.create_dump;
    assign read_data_out      = mem_Done ? mem_DataOut : '0;

endmodule

// File: tb/tb_ex_mem.sv
// Randomized self-checking bench for ex_mem against a transaction-level model of the MEM stage.
module tb_ex_mem;

`ifdef EX_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk, rst;
    logic [15:0] ALU_result_in, read2Data_in, PC_plus_two_in, mem_DataOut;
    logic [2:0]  Write_register_in;
    logic        RegWrite_in, MemWrite_in, MemRead_in, MemtoReg_in, link_in, halt_in, createdump_in;
    logic        flush, mem_Done, mem_err;
    logic [15:0] mem_Addr, mem_DataIn, ALU_result_out, PC_plus_two_out, read_data_out;
    logic [2:0]  Write_register_out;
    logic        mem_Rd, mem_Wr, RegWrite_out, MemtoReg_out, link_out, halt_out, createdump_out;
    logic        stall_out, err_out;

    ex_mem dut (
        .clk(clk), .rst(rst),
        .ALU_result_in(ALU_result_in), .read2Data_in(read2Data_in),
        .PC_plus_two_in(PC_plus_two_in), .Write_register_in(Write_register_in),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemtoReg_in(MemtoReg_in), .link_in(link_in), .halt_in(halt_in),
        .createdump_in(createdump_in), .flush(flush),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_err(mem_err),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .ALU_result_out(ALU_result_out), .PC_plus_two_out(PC_plus_two_out),
        .Write_register_out(Write_register_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .link_out(link_out), .halt_out(halt_out),
        .createdump_out(createdump_out), .read_data_out(read_data_out),
        .stall_out(stall_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instruction currently in MEM plus a sticky error flag.
    typedef struct {
        logic [15:0] alu, r2, pc2;
        logic [2:0]  wr;
        bit rw, mw, mr, m2r, lnk, hlt, dmp;
    } bundle_t;

    bundle_t m;
    bit      m_err;
    int      checks = 0;
    int      failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit wants_mem();
        return !m_err && (m.mw || m.mr) && !m.hlt;
    endfunction

    function automatic bit exp_mis();
        return ALIGN && wants_mem() && m.alu[0];
    endfunction

    function automatic bit exp_acc();
        return wants_mem() && !exp_mis();
    endfunction

    function automatic bit exp_stall();
        return exp_acc() && !mem_Done;
    endfunction

    task automatic compare_all();
        check("mem_Addr",   32'(mem_Addr),           32'(m.alu));
        check("mem_DataIn", 32'(mem_DataIn),         32'(m.r2));
        check("mem_Wr",     32'(mem_Wr),             32'(exp_acc() && m.mw));
        check("mem_Rd",     32'(mem_Rd),             32'(exp_acc() && m.mr && !m.mw));
        check("stall",      32'(stall_out),          32'(exp_stall()));
        check("err",        32'(err_out),            32'(m_err));
        check("alu_out",    32'(ALU_result_out),     32'(m.alu));
        check("pc2_out",    32'(PC_plus_two_out),    32'(m.pc2));
        check("wreg_out",   32'(Write_register_out), 32'(m.wr));
        check("regwr_out",  32'(RegWrite_out),       32'(m.rw && !m_err));
        check("m2r_out",    32'(MemtoReg_out),       32'(m.m2r));
        check("link_out",   32'(link_out),           32'(m.lnk));
        check("halt_out",   32'(halt_out),           32'(m.hlt));
        check("dump_out",   32'(createdump_out),     32'(m.dmp));
        check("rdata",      32'(read_data_out),      32'(mem_Done ? mem_DataOut : 16'h0));
    endtask

    task automatic model_edge();
        bit st, nerr;
        st   = exp_stall();
        nerr = m_err || mem_err || exp_mis();
        if (rst) begin
            m     = '{default: 0};
            m_err = 1'b0;
        end else begin
            if (!st) begin
                m.alu = ALU_result_in;  m.r2  = read2Data_in;
                m.pc2 = PC_plus_two_in; m.wr  = Write_register_in;
                m.m2r = MemtoReg_in;    m.lnk = link_in;
                m.rw  = RegWrite_in   && !flush;
                m.mw  = MemWrite_in   && !flush;
                m.mr  = MemRead_in    && !flush;
                m.hlt = halt_in       && !flush;
                m.dmp = createdump_in && !flush;
            end
            m_err = nerr;
        end
    endtask

    // Inputs are already driven; check this cycle, clock it, advance the model.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic clear_in();
        ALU_result_in = '0; read2Data_in = '0; PC_plus_two_in = '0; Write_register_in = '0;
        RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemtoReg_in = 0;
        link_in = 0; halt_in = 0; createdump_in = 0; flush = 0;
        mem_DataOut = '0; mem_Done = 0; mem_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m = '{default: 0};
        m_err = 1'b0;
        #2;
        do_reset();
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_err",   32'(err_out),   32'd0);

        // Single-cycle load
        MemRead_in = 1; ALU_result_in = 16'h0040; step();
        clear_in(); mem_Done = 1; mem_DataOut = 16'hBEEF;
        #1;
        check("ld_rd",    32'(mem_Rd),        32'd1);
        check("ld_data",  32'(read_data_out), 32'h0000BEEF);
        check("ld_stall", 32'(stall_out),     32'd0);
        step();
        clear_in(); step();

        // Four-cycle store; next bundle waits, then loads on the Done edge
        MemWrite_in = 1; ALU_result_in = 16'h0100; read2Data_in = 16'h1234; step();
        clear_in(); RegWrite_in = 1; Write_register_in = 3'd5; ALU_result_in = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_wr",    32'(mem_Wr),    32'd1);
            check("st_stall", 32'(stall_out), 32'd1);
            check("st_addr",  32'(mem_Addr),  32'h0100);
            step();
        end
        mem_Done = 1; step();
        mem_Done = 0;
        check("st_next", 32'(ALU_result_out), 32'h2222);

        // Flush at capture, then flush while stalled
        clear_in(); RegWrite_in = 1; MemWrite_in = 1; flush = 1; step();
        clear_in();
        check("fl_rw", 32'(RegWrite_out), 32'd0);
        check("fl_wr", 32'(mem_Wr),       32'd0);
        step();
        MemWrite_in = 1; ALU_result_in = 16'h0200; step();
        clear_in(); flush = 1; step();
        flush = 0; mem_Done = 1;
        #1;
        check("flb_wr", 32'(mem_Wr), 32'd1);
        step();

        // Error during BUSY
        clear_in(); MemWrite_in = 1; ALU_result_in = 16'h0300; step();
        clear_in(); RegWrite_in = 1; step();
        mem_err = 1; step();
        mem_err = 0; step();
        check("er_err", 32'(err_out),      32'd1);
        check("er_wr",  32'(mem_Wr),       32'd0);
        check("er_st",  32'(stall_out),    32'd0);
        check("er_rw",  32'(RegWrite_out), 32'd0);
        clear_in(); mem_Done = 1; MemRead_in = 1; step(); step();
        check("er_sticky", 32'(err_out), 32'd1);
        clear_in(); do_reset();

        // Odd address load
        MemRead_in = 1; ALU_result_in = 16'h0041; step();
        clear_in(); mem_Done = 1;
        #1;
        check("al_rd",   32'(mem_Rd),   32'(!ALIGN));
        check("al_addr", 32'(mem_Addr), 32'h0041);
        step();
        check("al_err", 32'(err_out), 32'(ALIGN));
        clear_in(); do_reset();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst               = ($urandom_range(0, 59) == 0);
            ALU_result_in     = 16'($urandom);
            if ($urandom_range(0, 7) != 0) ALU_result_in[0] = 1'b0;
            read2Data_in      = 16'($urandom);
            PC_plus_two_in    = 16'($urandom);
            Write_register_in = 3'($urandom);
            RegWrite_in       = 1'($urandom);
            MemWrite_in       = ($urandom_range(0, 2) == 0);
            MemRead_in        = ($urandom_range(0, 2) == 0);
            MemtoReg_in       = 1'($urandom);
            link_in           = 1'($urandom);
            halt_in           = ($urandom_range(0, 15) == 0);
            createdump_in     = ($urandom_range(0, 15) == 0);
            flush             = ($urandom_range(0, 4) == 0);
            mem_DataOut       = 16'($urandom);
            mem_Done          = ($urandom_range(0, 2) == 0);
            mem_err           = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
